ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the MIPS ALU.
- Registers the ALU result and flags together with the instruction, and resolves beq/bne branches.
- Raises an overflow trap for add/addi/sub.
- Produces the memory and write-back controls consumed by the MEM/WB logic, with a valid/ready handshake on both sides.

Parameters:
- XLEN, 32, datapath width (fixed at 32; parameterised only for bench clarity)
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ALU-side payload valid
- in_ready  out  1  stage can accept payload
- instruction  in  32  instruction evaluated by ALU this cycle
- alu_result  in  32  ALU result
- alu_flag  in  3  [0] zero, [1] negative, [2] overflow
- store_data  in  32  regB value (sw data)
- pc_plus4  in  32  PC of instruction + 4
- flush  in  1  kill the registered entry and the incoming capture
- out_valid  out  1  registered entry valid
- out_ready  in  1  downstream accepts entry
- wb_value  out  32  value to write back or memory address
- mem_wdata  out  32  registered store_data
- wb_reg  out  5  destination register
- reg_we  out  1  register write enable
- mem_read  out  1  lw
- mem_write  out  1  sw
- branch_taken  out  1  resolved taken beq/bne (qualified by out_valid)
- branch_target  out  32  pc_plus4 + (sext(imm) << 2)
- exc  out  1  overflow trap pending
- epc  out  32  pc_plus4 - 4 of trapping instruction
- exc_ack  in  1  trap handler acknowledges
- retired_cnt  out  CNT_W  entries accepted downstream

Behaviour:
- Reset (sync, reset=1 at posedge): all outputs 0; state RUN; retired_cnt 0. Reset overrides flush, exc_ack and any capture.
- States:
  - RUN: normal operation.
  - TRAP: entered when an overflowing add/addi/sub is captured; leave to RUN on the cycle exc_ack=1.
- in_ready = (state==RUN) && (!out_valid || out_ready) && !flush.
- Capture on in_valid && in_ready. Registered outputs are valid the next cycle: one-cycle latency. Payload is held stable while out_valid && !out_ready.
- Decode (opcode = instruction[31:26], funct = instruction[5:0]):
  - R-type add/addu/sub/subu/and/or/nor/xor/sll/sllv/srl/srlv/sra/srav: wb_reg = rd.
  - addi/addiu/andi/ori/xori/slti/sltiu: wb_reg = rt.
  - lw: wb_reg = rt, mem_read = 1, reg_we = 1, wb_value = alu_result.
  - sw: mem_write = 1, reg_we = 0, wb_value = alu_result, mem_wdata = store_data.
  - beq: branch_taken = alu_flag[0]. bne: branch_taken = !alu_flag[0]. For both, reg_we = 0.
  - slt/slti/sltu/sltiu: wb_value = {31'b0, alu_flag[1]}. alu_result is ignored for these.
  - All other ALU ops: wb_value = alu_result.
  - Unknown encoding: out_valid = 1 with reg_we = mem_read = mem_write = branch_taken = 0 (bubble).
- reg_we is forced to 0 when wb_reg == 0.
- Overflow (add, addi, sub with alu_flag[2] = 1):
  - Entry captured as a bubble; all enables 0.
  - exc = 1 and epc = pc_plus4 - 4 in the cycle after capture.
  - State goes to TRAP; in_ready stays 0 until exc_ack.
  - On the exc_ack cycle: exc cleared next cycle, epc retained.
  - addu/subu/addiu never trap.
- branch_target is computed with 32-bit wrap-around; sext uses instruction[15].
- Handshake edge cases:
  - Simultaneous out_ready and new capture: entry replaced seamlessly (throughput 1/cycle).
  - out_valid may fall only via out_ready or flush.
- flush:
  - out_valid = 0 next cycle; in_ready is 0 that cycle, so no capture.
  - Does not affect TRAP, exc, epc or retired_cnt.
- retired_cnt:
  - Increments on out_valid && out_ready && !flush; wraps at 2^CNT_W.
  - Bubbles count; flushed entries do not.

Test Plan:
- add $3,$1,$2 with alu_result = 0x0000_0007, flag = 000, out_ready = 1 -> next cycle out_valid = 1, wb_reg = 3, reg_we = 1, wb_value = 7; retired_cnt 0 -> 1.
- slt with alu_result = 0xFFFF_FFFE, flag = 010 -> wb_value = 0x0000_0001. sltiu with flag = 000 -> wb_value = 0.
- beq at pc_plus4 = 0x0000_0104, imm = 0xFFFF, flag = 001 -> branch_taken = 1, branch_target = 0x0000_0100. Same as bne -> branch_taken = 0.
- addi with flag = 100, pc_plus4 = 0x40 -> exc = 1, epc = 0x3C, reg_we = 0, in_ready = 0 for 5 cycles. exc_ack pulse -> exc = 0 next cycle, in_ready returns to 1.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 -> payload stable, in_ready = 0. Release -> back-to-back captures at 1/cycle; retired_cnt counts each.
- Assert flush with out_valid = 1 and in_valid = 1 -> out_valid = 0 next cycle, no capture, retired_cnt unchanged. Assert reset mid-TRAP -> all outputs 0, state RUN.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the MIPS datapath: decodes write-back and memory
// controls, resolves beq/bne, and raises the overflow trap for add/addi/sub.
module ex_mem_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [2:0]       alu_flag,
  input  logic [XLEN-1:0]  store_data,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  wb_value,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [4:0]       wb_reg,
  output logic             reg_we,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch_taken,
  output logic [XLEN-1:0]  branch_target,
  output logic             exc,
  output logic [XLEN-1:0]  epc,
  input  logic             exc_ack,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [0:0] {RUN, TRAP} state_t;

  typedef struct packed {
    logic [XLEN-1:0] wb_value;
    logic [XLEN-1:0] mem_wdata;
    logic [4:0]      wb_reg;
    logic            reg_we;
    logic            mem_read;
    logic            mem_write;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
  } ent_t;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  state_t          state_q, state_d;
  logic            valid_q, valid_d;
  ent_t            ent_q, ent_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ent_t            dec;
  logic            dec_trap;
  logic            fire_in;
  logic            fire_out;

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [XLEN-1:0] boff;
  logic [XLEN-1:0] flag_lt;
  logic            unused_fields;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign boff   = {{(XLEN-18){instruction[15]}}, instruction[15:0], 2'b00};
  assign flag_lt = {{(XLEN-1){1'b0}}, alu_flag[1]};
  assign unused_fields = ^{instruction[25:21], instruction[10:6]};

  always_comb begin
    dec           = '0;
    dec.wb_value  = alu_result;
    dec.mem_wdata = store_data;
    dec.br_target = pc_plus4 + boff;
    dec_trap      = 1'b0;
    unique case (1'b1)
      opcode == OP_R: begin
        unique case (funct)
          F_ADD, F_SUB: begin
            dec_trap   = alu_flag[2];
            dec.wb_reg = rd;
            dec.reg_we = 1'b1;
          end
          F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
            dec.wb_reg = rd;
            dec.reg_we = 1'b1;
          end
          F_SLT, F_SLTU: begin
            dec.wb_reg   = rd;
            dec.reg_we   = 1'b1;
            dec.wb_value = flag_lt;
          end
          default: ;
        endcase
      end
      opcode == OP_ADDI: begin
        dec_trap   = alu_flag[2];
        dec.wb_reg = rt;
        dec.reg_we = 1'b1;
      end
      opcode == OP_ADDIU, opcode == OP_ANDI,
      opcode == OP_ORI, opcode == OP_XORI: begin
        dec.wb_reg = rt;
        dec.reg_we = 1'b1;
      end
      opcode == OP_SLTI, opcode == OP_SLTIU: begin
        dec.wb_reg   = rt;
        dec.reg_we   = 1'b1;
        dec.wb_value = flag_lt;
      end
      opcode == OP_LW: begin
        dec.wb_reg   = rt;
        dec.reg_we   = 1'b1;
        dec.mem_read = 1'b1;
      end
      opcode == OP_SW:  dec.mem_write = 1'b1;
      opcode == OP_BEQ: dec.br_taken  = alu_flag[0];
      opcode == OP_BNE: dec.br_taken  = !alu_flag[0];
      default: ;
    endcase
    // a trapping instruction retires as a bubble
    if (dec_trap) begin
      dec.wb_reg   = '0;
      dec.reg_we   = 1'b0;
      dec.mem_read = 1'b0;
    end
    if (dec.wb_reg == 5'd0) dec.reg_we = 1'b0;
  end

  assign in_ready = !reset && (state_q == RUN) &&
                    (!valid_q || out_ready) && !flush;
  assign fire_in  = in_valid && in_ready;
  assign fire_out = valid_q && out_ready && !flush;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ent_d   = ent_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    if (fire_out) cnt_d = cnt_q + CNT_W'(1);
    if (flush) begin
      valid_d = 1'b0;
    end else if (fire_in) begin
      valid_d = 1'b1;
      ent_d   = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (state_q == TRAP && exc_ack) state_d = RUN;
    if (fire_in && dec_trap) begin
      state_d = TRAP;
      epc_d   = pc_plus4 - XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      ent_q   <= '0;
      epc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ent_q   <= ent_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign wb_value      = ent_q.wb_value;
  assign mem_wdata     = ent_q.mem_wdata;
  assign wb_reg        = ent_q.wb_reg;
  assign reg_we        = valid_q && ent_q.reg_we;
  assign mem_read      = valid_q && ent_q.mem_read;
  assign mem_write     = valid_q && ent_q.mem_write;
  assign branch_taken  = valid_q && ent_q.br_taken;
  assign branch_target = ent_q.br_target;
  assign exc           = (state_q == TRAP);
  assign epc           = epc_q;
  assign retired_cnt   = cnt_q;

endmodule
